// File: rtl/seg7_scan_ctrl_if.sv
// Peripheral-bus port bundle for the seven-segment scan controller.
// The CPU side drives writes and the register select. The display block
// returns combinational readback of the selected register.
interface seg7_scan_ctrl_if;
  logic        seg_wr_en;
  logic        seg_addr;
  logic [31:0] seg_wr_data;
  logic [31:0] seg_rd_data;

  modport master (
    output seg_wr_en,
    output seg_addr,
    output seg_wr_data,
    input  seg_rd_data
  );

  modport slave (
    input  seg_wr_en,
    input  seg_addr,
    input  seg_wr_data,
    output seg_rd_data
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit seven-segment display controller.
// Software writes a packed hex VALUE and a CTRL word. These are copied into
// display latches only at frame boundaries, or continuously while the
// display is disabled, so a frame never shows a torn value. Each digit slot
// opens with a short all-off interval that stops ghosting between digits.
module seg7_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_ctrl_if.slave   bus,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int VAL_W   = 4 * DIGITS;
  localparam int CTRL_W  = 2 * DIGITS + 2;
  localparam int EN_BIT  = 2 * DIGITS;
  localparam int LZS_BIT = 2 * DIGITS + 1;
  localparam int CNT_W   = $clog2(SCAN_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [VAL_W-1:0]  value_q, value_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [VAL_W-1:0]  dval_q, dval_d;
  logic [CTRL_W-1:0] dctrl_q, dctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              scan_en;
  logic              frame_end;
  logic [DIGITS-1:0] dp_mask;
  logic [DIGITS-1:0] blank_mask;
  logic [3:0]        cur_nibble;
  logic              upper_zero;
  logic              digit_blank;

  // Active-low gfedcba patterns for hex digits 0..F.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  // Readback shows the software-visible registers, zero-extended to 32 bits.
  assign bus.seg_rd_data = bus.seg_addr ? 32'(ctrl_q) : 32'(value_q);

  assign scan_en   = dctrl_q[EN_BIT];
  assign frame_end = scan_en && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

  // Bus registers take the low bits of a write and drop the rest.
  always_comb begin
    value_d = value_q;
    ctrl_d  = ctrl_q;
    if (bus.seg_wr_en) begin
      if (bus.seg_addr) ctrl_d  = bus.seg_wr_data[CTRL_W-1:0];
      else              value_d = bus.seg_wr_data[VAL_W-1:0];
    end
  end

  // Display latches follow the bus registers while disabled and otherwise only at the last cycle of a frame.
  always_comb begin
    dval_d  = dval_q;
    dctrl_d = dctrl_q;
    if (!scan_en || frame_end) begin
      dval_d  = value_q;
      dctrl_d = ctrl_q;
    end
  end

  // Slot counter and digit index advance only while the latched enable is set.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!scan_en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Work out whether the digit under scan is blank, either by mask or by leading-zero suppression.
  always_comb begin
    dp_mask     = dctrl_q[DIGITS-1:0];
    blank_mask  = dctrl_q[2*DIGITS-1:DIGITS];
    cur_nibble  = dval_q[{idx_q, 2'b00} +: 4];
    upper_zero  = ((dval_q >> {idx_q, 2'b00}) == '0);
    digit_blank = blank_mask[idx_q] ||
                  (dctrl_q[LZS_BIT] && (idx_q != '0) && upper_zero);
  end

  // Next output pattern. Segments load for the whole slot, but the anode waits out the blank interval.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (scan_en && !digit_blank) begin
      seg_d = decode_hex(cur_nibble);
      dp_d  = ~dp_mask[idx_q];
      if (cnt_q >= CNT_BLANK) an_d[idx_q] = 1'b0;
    end
  end

  // All state, with an asynchronous return to a dark display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      ctrl_q  <= '0;
      dval_q  <= '0;
      dctrl_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      dval_q  <= dval_d;
      dctrl_q <= dctrl_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a small 4-digit, 8-cycle-slot setup.
// A behavioural model tracks the registers plus a single running time count
// since scanning started. It derives digit and phase from that count and
// predicts the outputs for every cycle.
module tb_seg7_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * SCAN_DIV;
  localparam int VAL_W     = 4 * DIGITS;
  localparam int CTRL_W    = 2 * DIGITS + 2;
  localparam int EN_BIT    = 2 * DIGITS;
  localparam int LZS_BIT   = 2 * DIGITS + 1;

  logic              clk;
  logic              reset;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  // 10-unit clock; the bench drives and samples on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [VAL_W-1:0]  m_value;
  logic [CTRL_W-1:0] m_ctrl;
  logic [VAL_W-1:0]  m_dval;
  logic [CTRL_W-1:0] m_dctrl;
  int                m_t;
  logic [DIGITS-1:0] exp_an;
  logic [6:0]        exp_seg;
  logic              exp_dp;
  int                low_cnt [DIGITS];

  // Spec decode table, indexed by nibble value.
  function automatic logic [6:0] segPattern(input int n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Model the clock edge: predict outputs from the pre-edge state, then advance the state.
  task automatic modelEdge(input logic we, input logic a, input logic [31:0] d);
    bit en, blank, frame_end;
    int k, ph, upper;
    en        = m_dctrl[EN_BIT];
    k         = (m_t / SCAN_DIV) % DIGITS;
    ph        = m_t % SCAN_DIV;
    frame_end = en && ((m_t % FRAME) == FRAME - 1);
    upper     = int'(m_dval >> (4 * k));
    blank     = m_dctrl[DIGITS + k] || (m_dctrl[LZS_BIT] && k != 0 && upper == 0);
    exp_an  = '1;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    if (en && !blank) begin
      exp_seg = segPattern(upper % 16);
      exp_dp  = ~m_dctrl[k];
      if (ph >= BLANK_CYC) exp_an = ~(DIGITS'(1) << k);
    end
    if (!en || frame_end) begin
      m_dval  = m_value;
      m_dctrl = m_ctrl;
    end
    m_t = en ? m_t + 1 : 0;
    if (we) begin
      if (a) m_ctrl  = d[CTRL_W-1:0];
      else   m_value = d[VAL_W-1:0];
    end
  endtask

  // One bus cycle, entered and left on a falling edge, with readback and output checks.
  task automatic applyStimulus(input logic we, input logic a, input logic [31:0] d);
    bus.seg_wr_en   = we;
    bus.seg_addr    = a;
    bus.seg_wr_data = d;
    #1;
    checkOutput("rd_data", bus.seg_rd_data, a ? 32'(m_ctrl) : 32'(m_value));
    @(posedge clk);
    modelEdge(we, a, d);
    @(negedge clk);
    bus.seg_wr_en = 1'b0;
    checkOutput("an", 32'(an), 32'(exp_an));
    checkOutput("seg", 32'(seg), 32'(exp_seg));
    checkOutput("dp", 32'(dp), 32'(exp_dp));
    for (int i = 0; i < DIGITS; i++) if (an[i] == 1'b0) low_cnt[i]++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom);
  endtask

  // Measure anode-low cycles per digit over two whole frames.
  task automatic countFrames(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_cnt [DIGITS];
    exp_cnt = '{e0, e1, e2, e3};
    for (int i = 0; i < DIGITS; i++) low_cnt[i] = 0;
    idle(2 * FRAME);
    for (int i = 0; i < DIGITS; i++)
      checkOutput($sformatf("%s_an%0d_low", tag, i), 32'(low_cnt[i]), 32'(exp_cnt[i]));
  endtask

  // Asynchronous reset, checked before any clock edge arrives.
  task automatic doReset;
    bus.seg_wr_en = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_dp", 32'(dp), 32'h1);
    bus.seg_addr = 1'b0;
    #1;
    checkOutput("rst_rd_value", bus.seg_rd_data, 32'h0);
    bus.seg_addr = 1'b1;
    #1;
    checkOutput("rst_rd_ctrl", bus.seg_rd_data, 32'h0);
    m_value = '0;
    m_ctrl  = '0;
    m_dval  = '0;
    m_dctrl = '0;
    m_t     = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    logic [31:0] rdata;
    logic        raddr;
    reset           = 1'b0;
    bus.seg_wr_en   = 1'b0;
    bus.seg_addr    = 1'b0;
    bus.seg_wr_data = '0;
    @(negedge clk);
    doReset();

    // Basic scan of 1A8F.
    applyStimulus(1'b1, 1'b0, 32'hFFFF_1A8F);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    idle(10);
    countFrames("basic", 12, 12, 12, 12);

    // Tear-free update: write zero while digit 1 is being scanned.
    guard = 0;
    while (((m_t / SCAN_DIV) % DIGITS) != 1 && guard < FRAME) begin
      idle(1);
      guard++;
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    idle(FRAME + 8);

    // LZS, blank mask and DP on 0050.
    applyStimulus(1'b1, 1'b0, 32'h0000_0050);
    applyStimulus(1'b1, 1'b1, 32'h0000_0312);
    idle(FRAME + 8);
    countFrames("lzs", 0, 12, 0, 0);

    // All-zero value with LZS leaves only digit 0 lit.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0300);
    idle(FRAME + 8);
    countFrames("zero", 12, 0, 0, 0);

    // Disable mid-frame: dark after the frame completes.
    idle(5);
    applyStimulus(1'b1, 1'b1, 32'h0);
    idle(FRAME + 4);
    checkOutput("disabled_an", 32'(an), 32'hF);
    countFrames("off", 0, 0, 0, 0);

    // Re-enable, then reset in the middle of a slot.
    applyStimulus(1'b1, 1'b0, 32'h0000_9C3E);
    applyStimulus(1'b1, 1'b1, 32'h0000_01A5);
    idle(13);
    doReset();

    // Randomized writes, mostly keeping the display enabled.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(5) == 0) begin
        raddr = 1'($urandom_range(1));
        rdata = $urandom;
        if (raddr) rdata[EN_BIT] = ($urandom_range(3) != 0);
        applyStimulus(1'b1, raddr, rdata);
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(1)), $urandom);
      end
      if (n == 1000) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
